// File: rtl/inmp441_mic_i2s_transmitter_pkg.sv
// Shared constants and types for the INMP441-style I2S slave transmitter.
// ClkMhz must be at least 8x the sck frequency for the oversampled edge detection.
package inmp441_mic_i2s_transmitter_pkg;

    localparam int unsigned ClkMhz    = 50;
    localparam int unsigned SampleW   = 24;
    localparam int unsigned SlotBits  = 32;
    localparam int unsigned FrameBits = 2 * SlotBits;
    localparam int unsigned CntW      = $clog2(SlotBits);

    typedef logic [CntW-1:0] bit_cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StOther
    } slot_state_e;

endpackage

// File: rtl/inmp441_mic_i2s_transmitter_if.sv
// Sample stream into the transmitter: valid/ready transfer of one sample per own slot.
interface inmp441_mic_i2s_transmitter_if;
    import inmp441_mic_i2s_transmitter_pkg::*;

    logic [SampleW-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/inmp441_mic_i2s_transmitter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus 1-clk rise/fall pulses.
module inmp441_mic_i2s_transmitter_sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/inmp441_mic_i2s_transmitter.sv
// I2S slave transmitter emulating an INMP441: shifts held samples out on sd, timed by the
// externally supplied sck/ws, which are oversampled in the clk domain.
module inmp441_mic_i2s_transmitter
    import inmp441_mic_i2s_transmitter_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_lr,
    input  logic                                i_ws,
    input  logic                                i_sck,
    output logic                                o_sd,
    output logic                                o_sd_oe,
    output logic                                o_underflow,
    output logic                                o_slot_start,
    inmp441_mic_i2s_transmitter_if.slave        sample_if
);

    localparam bit_cnt_t CntMax   = bit_cnt_t'(SlotBits - 1);
    localparam bit_cnt_t CntOeEnd = bit_cnt_t'(SampleW);

    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_ws_sync, w_ws_rise, w_ws_fall;
    logic w_lr_sync, w_lr_rise, w_lr_fall;
    logic w_unused;

    inmp441_mic_i2s_transmitter_sync_edge_detect u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .i_async(i_sck),
        .o_sync (w_sck_sync),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    inmp441_mic_i2s_transmitter_sync_edge_detect u_sync_ws (
        .clk    (clk),
        .rst    (rst),
        .i_async(i_ws),
        .o_sync (w_ws_sync),
        .o_rise (w_ws_rise),
        .o_fall (w_ws_fall)
    );

    inmp441_mic_i2s_transmitter_sync_edge_detect u_sync_lr (
        .clk    (clk),
        .rst    (rst),
        .i_async(i_lr),
        .o_sync (w_lr_sync),
        .o_rise (w_lr_rise),
        .o_fall (w_lr_fall)
    );

    assign w_unused = ^{w_sck_sync, w_ws_rise, w_ws_fall, w_lr_rise, w_lr_fall};

    slot_state_e        r_state, w_state_d;
    bit_cnt_t           r_bit_cnt, w_bit_cnt_d;
    logic [SampleW-1:0] r_shift, w_shift_d;
    logic [SampleW-1:0] r_hold, w_hold_d;
    logic               r_hold_full, w_hold_full_d;
    logic               r_ws_cap, w_ws_cap_d;
    logic               r_ws_prev, w_ws_prev_d;
    logic               r_sd_oe, w_sd_oe_d;
    logic               r_underflow, w_underflow_d;
    logic               r_slot_start, w_slot_start_d;
    logic               w_accept;

    assign w_accept = sample_if.valid & ~r_hold_full;

    always_comb begin
        w_state_d      = r_state;
        w_bit_cnt_d    = r_bit_cnt;
        w_shift_d      = r_shift;
        w_hold_d       = r_hold;
        w_hold_full_d  = r_hold_full;
        w_ws_cap_d     = r_ws_cap;
        w_ws_prev_d    = r_ws_prev;
        w_sd_oe_d      = r_sd_oe;
        w_underflow_d  = 1'b0;
        w_slot_start_d = 1'b0;

        if (w_accept) begin
            w_hold_d      = sample_if.data;
            w_hold_full_d = 1'b1;
        end

        if (w_sck_rise) begin
            w_ws_cap_d = w_ws_sync;
        end

        if (w_sck_fall) begin
            w_ws_prev_d = r_ws_cap;
            // WS captured on the previous rise differs: MSB goes out one sck after the WS edge
            if (r_ws_cap != r_ws_prev) begin
                w_bit_cnt_d = '0;
                if (r_ws_cap == w_lr_sync) begin
                    w_state_d      = StOwn;
                    w_sd_oe_d      = 1'b1;
                    w_slot_start_d = 1'b1;
                    if (r_hold_full) begin
                        w_shift_d     = r_hold;
                        w_hold_full_d = 1'b0;
                    end else begin
                        w_shift_d     = '0;
                        w_underflow_d = 1'b1;
                    end
                end else begin
                    w_state_d = StOther;
                    w_shift_d = '0;
                    w_sd_oe_d = 1'b0;
                end
            end else begin
                if (r_bit_cnt != CntMax) begin
                    w_bit_cnt_d = r_bit_cnt + bit_cnt_t'(1);
                end
                if (r_state == StOwn) begin
                    w_shift_d = {r_shift[SampleW-2:0], 1'b0};
                    w_sd_oe_d = (w_bit_cnt_d < CntOeEnd);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_bit_cnt    <= CntMax;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_ws_cap     <= 1'b0;
            r_ws_prev    <= 1'b0;
            r_sd_oe      <= 1'b0;
            r_underflow  <= 1'b0;
            r_slot_start <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_shift      <= w_shift_d;
            r_hold       <= w_hold_d;
            r_hold_full  <= w_hold_full_d;
            r_ws_cap     <= w_ws_cap_d;
            r_ws_prev    <= w_ws_prev_d;
            r_sd_oe      <= w_sd_oe_d;
            r_underflow  <= w_underflow_d;
            r_slot_start <= w_slot_start_d;
        end
    end

    assign o_sd            = r_sd_oe & r_shift[SampleW-1];
    assign o_sd_oe         = r_sd_oe;
    assign o_underflow     = r_underflow;
    assign o_slot_start    = r_slot_start;
    assign sample_if.ready = ~r_hold_full;

endmodule
